// File: rtl/psc_trigger_multi.sv
// Multi-channel PSC trigger: synchronised EVR edge -> programmable delay, pulse width, holdoff.
// Define PSC_TRIG_MISS_CNT_EN to build the per-channel dropped-trigger counters.
module psc_trigger_multi #(
   parameter int N_CH        = 4,
   parameter int SYNC_STAGES = 2,
   parameter int DLY_W       = 16,
   parameter int WID_W       = 16,
   parameter int HOLDOFF     = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_CH-1:0]       enable,
   input  logic [N_CH-1:0]       evr_trigger,
   input  logic [N_CH*DLY_W-1:0] cfg_delay,
   input  logic [N_CH*WID_W-1:0] cfg_width,
   output logic [N_CH-1:0]       psc_output,
   output logic [N_CH-1:0]       busy,
   output logic [N_CH*8-1:0]     miss_count
);

   localparam int HO_W    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam int DW_MAX  = (DLY_W > WID_W) ? DLY_W : WID_W;
   localparam int CNT_W   = (DW_MAX > HO_W) ? DW_MAX : HO_W;

   typedef enum logic [1:0] {IDLE, DELAY, PULSE, HOLD} state_t;

   genvar i;
   for (i = 0; i < N_CH; i++) begin : g_ch
      logic [SYNC_STAGES-1:0] sync_q;
      logic [SYNC_STAGES-1:0] valid_q;
      logic                   sync_prev;
      logic                   seen_low;
      logic                   rise_q;
      state_t                 state;
      state_t                 next_state;
      logic [CNT_W-1:0]       cnt;
      logic [CNT_W-1:0]       next_cnt;
      logic [CNT_W-1:0]       w_lat;
      logic [CNT_W-1:0]       w_eff;
      logic [DLY_W-1:0]       d_in;
      logic [WID_W-1:0]       w_in;
      logic                   accept;
      logic                   out_q;
      logic                   busy_q;

      assign d_in   = cfg_delay[i*DLY_W +: DLY_W];
      assign w_in   = cfg_width[i*WID_W +: WID_W];
      assign w_eff  = (w_in == '0) ? CNT_W'(1) : CNT_W'(w_in);
      assign accept = (state == IDLE) && rise_q && enable[i];

      // seen_low blocks a fake edge from an input that was already high through reset
      always_ff @(posedge clk) begin
         if (reset) begin
            sync_q    <= '0;
            valid_q   <= '0;
            sync_prev <= 1'b0;
            seen_low  <= 1'b0;
            rise_q    <= 1'b0;
         end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], evr_trigger[i]};
            valid_q   <= {valid_q[SYNC_STAGES-2:0], 1'b1};
            sync_prev <= sync_q[SYNC_STAGES-1];
            seen_low  <= seen_low | (valid_q[SYNC_STAGES-1] & ~sync_q[SYNC_STAGES-1]);
            rise_q    <= sync_q[SYNC_STAGES-1] & ~sync_prev & seen_low;
         end
      end

      always_comb begin
         next_state = state;
         next_cnt   = cnt;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (d_in != '0) begin
                     next_state = DELAY;
                     next_cnt   = CNT_W'(d_in);
                  end else begin
                     next_state = PULSE;
                     next_cnt   = w_eff;
                  end
               end
            end
            DELAY: begin
               if (cnt == CNT_W'(1)) begin
                  next_state = PULSE;
                  next_cnt   = w_lat;
               end else begin
                  next_cnt   = cnt - CNT_W'(1);
               end
            end
            PULSE: begin
               if (cnt == CNT_W'(1)) begin
                  if (HOLDOFF == 0) begin
                     next_state = IDLE;
                  end else begin
                     next_state = HOLD;
                     next_cnt   = CNT_W'(HOLDOFF);
                  end
               end else begin
                  next_cnt   = cnt - CNT_W'(1);
               end
            end
            HOLD: begin
               if (cnt == CNT_W'(1)) begin
                  next_state = IDLE;
               end else begin
                  next_cnt   = cnt - CNT_W'(1);
               end
            end
            default: next_state = IDLE;
         endcase
      end

      // Outputs are decoded from next_state so they are glitch-free flops aligned with state
      always_ff @(posedge clk) begin
         if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            w_lat  <= '0;
            out_q  <= 1'b0;
            busy_q <= 1'b0;
         end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            if (accept) begin
               w_lat <= w_eff;
            end
            out_q  <= (next_state == PULSE);
            busy_q <= (next_state != IDLE);
         end
      end

      assign psc_output[i] = out_q;
      assign busy[i]       = busy_q;

`ifdef PSC_TRIG_MISS_CNT_EN
      logic       drop;
      logic [7:0] miss_q;

      assign drop = rise_q & enable[i] & (state != IDLE);

      always_ff @(posedge clk) begin
         if (reset) begin
            miss_q <= 8'h00;
         end else if (drop && (miss_q != 8'hFF)) begin
            miss_q <= miss_q + 8'd1;
         end
      end

      assign miss_count[i*8 +: 8] = miss_q;
`else
      assign miss_count[i*8 +: 8] = 8'h00;
`endif
   end

endmodule

// File: tb/tb_psc_trigger_multi.sv
// Scoreboard bench for psc_trigger_multi: a cycle-level reference model predicts each pulse
// (start edge, width), busy and miss counts; a monitor compares what the DUT produces.
module tb_psc_trigger_multi;

   localparam int N_CH        = 4;
   localparam int SYNC_STAGES = 2;
   localparam int DLY_W       = 16;
   localparam int WID_W       = 16;
   localparam int HOLDOFF     = 8;

   logic                  clk;
   logic                  reset;
   logic [N_CH-1:0]       enable;
   logic [N_CH-1:0]       evr_trigger;
   logic [N_CH*DLY_W-1:0] cfg_delay;
   logic [N_CH*WID_W-1:0] cfg_width;
   logic [N_CH-1:0]       psc_output;
   logic [N_CH-1:0]       busy;
   logic [N_CH*8-1:0]     miss_count;

   typedef struct {
      int start;
      int width;
   } pulse_t;

   pulse_t exp_q[N_CH][$];
   int     pend_q[N_CH][$];
   int     idle_edge[N_CH];
   int     acc_edge[N_CH];
   int     miss_mdl[N_CH];
   bit     prev_trig[N_CH];
   bit     prev_valid[N_CH];
   bit     mon_high[N_CH];
   int     mon_start[N_CH];

   int edge_n = -1;
   int total  = 0;
   int bad    = 0;

   psc_trigger_multi #(
      .N_CH(N_CH), .SYNC_STAGES(SYNC_STAGES), .DLY_W(DLY_W), .WID_W(WID_W), .HOLDOFF(HOLDOFF)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .evr_trigger(evr_trigger),
      .cfg_delay(cfg_delay),
      .cfg_width(cfg_width),
      .psc_output(psc_output),
      .busy(busy),
      .miss_count(miss_count)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      total++;
      if (actual != expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_n);
      end
   endtask

   task automatic atEdge(input int x);
      while (edge_n < x) @(negedge clk);
   endtask

   task automatic applyStimulus(input int ch, input int d, input int w);
      cfg_delay[ch*DLY_W +: DLY_W] = DLY_W'(d);
      cfg_width[ch*WID_W +: WID_W] = WID_W'(w);
   endtask

   function automatic int expMiss(input int ch);
`ifdef PSC_TRIG_MISS_CNT_EN
      return miss_mdl[ch];
`else
      return 0 * ch;
`endif
   endfunction

   // Reference model: tracks what the inputs sampled at each edge imply, in edge numbers
   always @(posedge clk) begin
      edge_n++;
      for (int ch = 0; ch < N_CH; ch++) begin
         if (reset) begin
            if (exp_q[ch].size() > 0) begin
               pulse_t last;
               last = exp_q[ch][exp_q[ch].size()-1];
               if (last.start + last.width - 1 >= edge_n) begin
                  if (last.start < edge_n)
                     exp_q[ch][exp_q[ch].size()-1].width = edge_n - last.start;
                  else
                     void'(exp_q[ch].pop_back());
               end
            end
            pend_q[ch].delete();
            idle_edge[ch]  = edge_n;
            acc_edge[ch]   = edge_n + 1;
            miss_mdl[ch]   = 0;
            prev_valid[ch] = 1'b0;
            prev_trig[ch]  = 1'b0;
         end else begin
            if (evr_trigger[ch] && prev_valid[ch] && !prev_trig[ch])
               pend_q[ch].push_back(edge_n + SYNC_STAGES + 1);
            prev_trig[ch]  = evr_trigger[ch];
            prev_valid[ch] = 1'b1;
            if (pend_q[ch].size() > 0 && pend_q[ch][0] == edge_n) begin
               void'(pend_q[ch].pop_front());
               if (enable[ch]) begin
                  if (edge_n > idle_edge[ch]) begin
                     pulse_t p;
                     int d;
                     int w;
                     d = int'(cfg_delay[ch*DLY_W +: DLY_W]);
                     w = int'(cfg_width[ch*WID_W +: WID_W]);
                     if (w == 0) w = 1;
                     p.start = edge_n + d;
                     p.width = w;
                     exp_q[ch].push_back(p);
                     acc_edge[ch]  = edge_n;
                     idle_edge[ch] = edge_n + d + w + HOLDOFF;
                  end else if (miss_mdl[ch] < 255) begin
                     miss_mdl[ch]++;
                  end
               end
            end
         end
      end
   end

   // Monitor: compares each DUT pulse against the head of its channel's expected queue
   always @(negedge clk) begin
      if (edge_n >= 0) begin
         for (int ch = 0; ch < N_CH; ch++) begin
            if (psc_output[ch] && !mon_high[ch]) begin
               mon_high[ch]  = 1'b1;
               mon_start[ch] = edge_n;
               if (exp_q[ch].size() == 0)
                  checkOutput($sformatf("unexpected pulse start ch%0d", ch), edge_n, -1);
               else
                  checkOutput($sformatf("pulse start ch%0d", ch), edge_n, exp_q[ch][0].start);
            end else if (!psc_output[ch] && mon_high[ch]) begin
               mon_high[ch] = 1'b0;
               if (exp_q[ch].size() == 0) begin
                  checkOutput($sformatf("unexpected pulse width ch%0d", ch), edge_n - mon_start[ch], -1);
               end else begin
                  checkOutput($sformatf("pulse width ch%0d", ch), edge_n - mon_start[ch], exp_q[ch][0].width);
                  void'(exp_q[ch].pop_front());
               end
            end else if (!psc_output[ch] && exp_q[ch].size() > 0 && exp_q[ch][0].start < edge_n) begin
               checkOutput($sformatf("missing pulse ch%0d", ch), -1, exp_q[ch][0].start);
               void'(exp_q[ch].pop_front());
            end
            checkOutput($sformatf("busy ch%0d", ch), int'(busy[ch]),
                        int'(acc_edge[ch] <= edge_n && edge_n < idle_edge[ch]));
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached at edge %0d", edge_n);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      reset       = 1'b1;
      enable      = '0;
      evr_trigger = '0;
      cfg_delay   = '0;
      cfg_width   = '0;
      for (int ch = 0; ch < N_CH; ch++) begin
         idle_edge[ch] = -1;
         acc_edge[ch]  = 0;
         miss_mdl[ch]  = 0;
         mon_high[ch]  = 1'b0;
         mon_start[ch] = 0;
      end

      atEdge(4);
      checkOutput("reset psc_output", int'(psc_output), 0);
      checkOutput("reset busy", int'(busy), 0);
      checkOutput("reset miss_count", int'(miss_count), 0);
      reset  = 1'b0;
      enable = 4'hF;
      applyStimulus(0, 0, 4);
      applyStimulus(1, 100, 300);
      applyStimulus(2, 5, 3);
      applyStimulus(3, 2, 0);

      // ch0 short pulse with a re-trigger during PULSE; ch1 long delayed pulse
      atEdge(9);
      evr_trigger[1:0] = 2'b11;
      atEdge(10);
      evr_trigger[0] = 1'b0;
      atEdge(11);
      evr_trigger[0] = 1'b1;
      atEdge(12);
      checkOutput("t1 out0 before start", int'(psc_output[0]), 0);
      atEdge(13);
      evr_trigger[0] = 1'b0;
      checkOutput("t1 out0 first high", int'(psc_output[0]), 1);
      atEdge(16);
      checkOutput("t1 out0 last high", int'(psc_output[0]), 1);
      atEdge(17);
      checkOutput("t1 out0 low", int'(psc_output[0]), 0);
      atEdge(19);
      evr_trigger[1] = 1'b0;
      atEdge(24);
      checkOutput("t1 busy0 in hold", int'(busy[0]), 1);
      atEdge(25);
      checkOutput("t1 busy0 idle", int'(busy[0]), 0);
`ifdef PSC_TRIG_MISS_CNT_EN
      checkOutput("t3 miss_count0", int'(miss_count[7:0]), 1);
`else
      checkOutput("t3 miss_count0", int'(miss_count[7:0]), 0);
`endif
      atEdge(112);
      checkOutput("t2 out1 before start", int'(psc_output[1]), 0);
      atEdge(113);
      checkOutput("t2 out1 first high", int'(psc_output[1]), 1);
      atEdge(200);
      checkOutput("t2 other channels", int'(psc_output & 4'b1101), 0);
      atEdge(412);
      checkOutput("t2 out1 last high", int'(psc_output[1]), 1);
      atEdge(413);
      checkOutput("t2 out1 low", int'(psc_output[1]), 0);

      // W=0 gives one cycle; width change mid-pulse is ignored
      atEdge(420);
      applyStimulus(2, 3, 0);
      applyStimulus(3, 0, 6);
      atEdge(429);
      evr_trigger[3:2] = 2'b11;
      atEdge(433);
      applyStimulus(3, 0, 1);
      atEdge(436);
      checkOutput("t4 out2 single high", int'(psc_output[2]), 1);
      atEdge(437);
      checkOutput("t4 out2 low", int'(psc_output[2]), 0);
      atEdge(438);
      checkOutput("t4 out3 last high", int'(psc_output[3]), 1);
      atEdge(439);
      checkOutput("t4 out3 low", int'(psc_output[3]), 0);
      atEdge(440);
      evr_trigger = '0;

      // reset mid-pulse, input held high through reset
      atEdge(450);
      applyStimulus(0, 0, 20);
      atEdge(459);
      evr_trigger[0] = 1'b1;
      atEdge(469);
      checkOutput("t5 out0 mid pulse", int'(psc_output[0]), 1);
      reset = 1'b1;
      atEdge(470);
      reset = 1'b0;
      checkOutput("t5 out0 after reset", int'(psc_output[0]), 0);
      checkOutput("t5 miss after reset", int'(miss_count), 0);
      atEdge(480);
      applyStimulus(0, 0, 4);
      atEdge(489);
      evr_trigger[0] = 1'b0;
      checkOutput("t5 no pulse while held", int'(psc_output[0]), 0);
      atEdge(494);
      evr_trigger[0] = 1'b1;
      atEdge(497);
      checkOutput("t5 out0 before new edge", int'(psc_output[0]), 0);
      atEdge(498);
      checkOutput("t5 out0 after new edge", int'(psc_output[0]), 1);
      atEdge(505);
      evr_trigger[0] = 1'b0;

      // all four channels on one edge
      atEdge(510);
      applyStimulus(0, 1, 2);
      applyStimulus(1, 7, 5);
      applyStimulus(2, 0, 9);
      applyStimulus(3, 12, 1);
      atEdge(519);
      evr_trigger = 4'hF;
      atEdge(523);
      checkOutput("t6 outputs at accept", int'(psc_output), 4'b0100);
      atEdge(525);
      evr_trigger = '0;
      atEdge(535);
      checkOutput("t6 out3 high", int'(psc_output[3]), 1);
      atEdge(536);
      checkOutput("t6 out3 low", int'(psc_output[3]), 0);

      // randomized traffic
      atEdge(600);
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 399) == 0);
         for (int ch = 0; ch < N_CH; ch++) begin
            if ($urandom_range(0, 5) == 0) evr_trigger[ch] = ~evr_trigger[ch];
            if ($urandom_range(0, 19) == 0) enable[ch] = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 29) == 0)
               applyStimulus(ch, $urandom_range(0, 15), $urandom_range(0, 10));
         end
         if (c % 250 == 249) begin
            for (int ch = 0; ch < N_CH; ch++)
               checkOutput($sformatf("rand miss_count ch%0d", ch), int'(miss_count[ch*8 +: 8]), expMiss(ch));
         end
         atEdge(edge_n + 1);
      end

      reset       = 1'b0;
      evr_trigger = '0;
      atEdge(edge_n + 100);
      for (int ch = 0; ch < N_CH; ch++) begin
         checkOutput($sformatf("final pending pulses ch%0d", ch), exp_q[ch].size(), 0);
         checkOutput($sformatf("final miss_count ch%0d", ch), int'(miss_count[ch*8 +: 8]), expMiss(ch));
      end
      checkOutput("final outputs idle", int'(psc_output), 0);
      checkOutput("final busy idle", int'(busy), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
